// File: rtl/ddr_port_arbiter_pkg.sv
// Shared types for the DDR user-port arbiter: FSM states and the client command bundle.
package ddr_port_arbiter_pkg;

  localparam int unsigned ADDR_W  = 27;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned MASK_W  = 8;
  localparam int unsigned RDATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_TURNAROUND
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              write;
    logic              read;
    logic              push;
    logic              pull;
    logic              done;
    logic [DATA_W-1:0] write_data;
    logic [MASK_W-1:0] write_mask;
  } cl_cmd_t;

endpackage

// File: rtl/ddr_port_arbiter_round_robin_picker.sv
// Combinational round-robin search: first set request at or after ptr_i, wrapping to bit 0.
module round_robin_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic          found_o
);

  // Two passes: upper segment [ptr..N-1] first, then the wrapped segment from bit 0.
  always_comb begin
    onehot_o = '0;
    found_o  = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found_o && (j >= 32'(ptr_i)) && req_i[j]) begin
        onehot_o[j] = 1'b1;
        found_o     = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found_o && req_i[j]) begin
        onehot_o[j] = 1'b1;
        found_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one DDR user port between NUM_PORTS cache bridges; whole-transaction ownership, round-robin.
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS-1:0]          release_i,
  output logic [NUM_PORTS-1:0]          hold_o,
  output logic [NUM_PORTS-1:0]          grant_o,
  input  logic [NUM_PORTS*ADDR_W-1:0]   cl_address_i,
  input  logic [NUM_PORTS-1:0]          cl_write_i,
  input  logic [NUM_PORTS-1:0]          cl_read_i,
  input  logic [NUM_PORTS-1:0]          cl_push_i,
  input  logic [NUM_PORTS-1:0]          cl_pull_i,
  input  logic [NUM_PORTS-1:0]          cl_done_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   cl_write_data_i,
  input  logic [NUM_PORTS*MASK_W-1:0]   cl_write_mask_i,
  output logic [NUM_PORTS*RDATA_W-1:0]  cl_read_data_o,
  output logic [NUM_PORTS-1:0]          cl_read_valid_o,
  output logic [NUM_PORTS-1:0]          cl_ready_o,
  output logic [ADDR_W-1:0]             ddr_address_o,
  output logic                          ddr_write_o,
  output logic                          ddr_read_o,
  output logic                          ddr_push_o,
  output logic                          ddr_pull_o,
  output logic                          ddr_done_o,
  output logic [DATA_W-1:0]             ddr_write_data_o,
  output logic [MASK_W-1:0]             ddr_write_mask_o,
  input  logic [RDATA_W-1:0]            ddr_read_data_i,
  input  logic                          ddr_read_valid_i,
  input  logic                          ddr_ready_i,
  output logic                          timeout_o
);

  localparam int unsigned PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

  arb_state_e           state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [NUM_PORTS-1:0] hold_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        ptr_d;
  logic [31:0]          cnt_q;
  logic                 timeout_q;

  logic [NUM_PORTS-1:0] pick;
  logic                 found;
  logic [PW-1:0]        owner_idx;
  logic                 owner_release;
  logic                 to_hit;
  cl_cmd_t              cmd [NUM_PORTS];
  cl_cmd_t              sel;

  round_robin_picker #(
    .N  (NUM_PORTS),
    .PW (PW)
  ) u_picker (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .onehot_o (pick),
    .found_o  (found)
  );

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      cmd[p] = '{address:    cl_address_i[p*ADDR_W +: ADDR_W],
                 write:      cl_write_i[p],
                 read:       cl_read_i[p],
                 push:       cl_push_i[p],
                 pull:       cl_pull_i[p],
                 done:       cl_done_i[p],
                 write_data: cl_write_data_i[p*DATA_W +: DATA_W],
                 write_mask: cl_write_mask_i[p*MASK_W +: MASK_W]};
    end
  end

  // grant_q is non-zero only in OWNED, so it alone gates every muxed path.
  always_comb begin
    sel             = '0;
    owner_idx       = '0;
    cl_read_data_o  = '0;
    cl_read_valid_o = '0;
    cl_ready_o      = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p]) begin
        sel                                = cmd[p];
        owner_idx                          = PW'(p);
        cl_read_data_o[p*RDATA_W +: RDATA_W] = ddr_read_data_i;
        cl_read_valid_o[p]                 = ddr_read_valid_i;
        cl_ready_o[p]                      = ddr_ready_i;
      end
    end
  end

  assign ptr_d         = (owner_idx == PW'(NUM_PORTS - 1)) ? '0 : owner_idx + 1'b1;
  assign owner_release = |(release_i & grant_q);
  assign to_hit        = (TIMEOUT_CYCLES != 0) && (state_q == ST_OWNED) &&
                         ((cnt_q + 32'd1) >= TO_LIM);

  assign ddr_address_o    = sel.address;
  assign ddr_write_o      = sel.write;
  assign ddr_read_o       = sel.read;
  assign ddr_push_o       = sel.push;
  assign ddr_pull_o       = sel.pull;
  assign ddr_done_o       = sel.done;
  assign ddr_write_data_o = sel.write_data;
  assign ddr_write_mask_o = sel.write_mask;
  assign grant_o          = grant_q;
  assign hold_o           = hold_q;
  // The flag shows during the OWNED cycle that completes the budget, then sticks.
  assign timeout_o        = timeout_q | to_hit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      hold_q    <= '1;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ddr_ready_i && found) begin
            grant_q <= pick;
            hold_q  <= ~pick;
            cnt_q   <= '0;
            state_q <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (cnt_q < TO_LIM) begin
            cnt_q <= cnt_q + 32'd1;
          end
          if (to_hit) begin
            timeout_q <= 1'b1;
          end
          if (owner_release) begin
            ptr_q   <= ptr_d;
            grant_q <= '0;
            hold_q  <= '1;
            state_q <= ST_TURNAROUND;
          end
        end
        ST_TURNAROUND: state_q <= ST_IDLE;
        default:       state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: directed table, hand sequences and random traffic against a transaction model.
module tb_ddr_port_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, rel, hold, grant;
  logic [N-1:0]    cl_write, cl_read, cl_push, cl_pull, cl_done;
  logic [N*27-1:0] cl_addr;
  logic [N*64-1:0] cl_wdata;
  logic [N*8-1:0]  cl_mask;
  logic [N*64-1:0] cl_rdata;
  logic [N-1:0]    cl_rvalid, cl_ready;
  logic [26:0]     ddr_addr;
  logic            ddr_write, ddr_read, ddr_push, ddr_pull, ddr_done;
  logic [63:0]     ddr_wdata;
  logic [7:0]      ddr_mask;
  logic [63:0]     ddr_rdata;
  logic            ddr_rvalid, ddr_ready;
  logic            timeout;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: who owns the port, gap pending, rotation start, owned-cycle count.
  int m_owner, m_ptr, m_cnt;
  bit m_ta, m_tflag;

  typedef struct packed {
    logic [1:0]  req;
    logic [1:0]  rel;
    logic        rdy;
    logic [1:0]  grant;
    logic [1:0]  hold;
    logic [1:0]  ready;
    logic [26:0] addr;
  } vec_t;
  vec_t tbl [18];

  ddr_port_arbiter #(
    .NUM_PORTS      (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .req_i            (req),
    .release_i        (rel),
    .hold_o           (hold),
    .grant_o          (grant),
    .cl_address_i     (cl_addr),
    .cl_write_i       (cl_write),
    .cl_read_i        (cl_read),
    .cl_push_i        (cl_push),
    .cl_pull_i        (cl_pull),
    .cl_done_i        (cl_done),
    .cl_write_data_i  (cl_wdata),
    .cl_write_mask_i  (cl_mask),
    .cl_read_data_o   (cl_rdata),
    .cl_read_valid_o  (cl_rvalid),
    .cl_ready_o       (cl_ready),
    .ddr_address_o    (ddr_addr),
    .ddr_write_o      (ddr_write),
    .ddr_read_o       (ddr_read),
    .ddr_push_o       (ddr_push),
    .ddr_pull_o       (ddr_pull),
    .ddr_done_o       (ddr_done),
    .ddr_write_data_o (ddr_wdata),
    .ddr_write_mask_o (ddr_mask),
    .ddr_read_data_i  (ddr_rdata),
    .ddr_read_valid_i (ddr_rvalid),
    .ddr_ready_i      (ddr_ready),
    .timeout_o        (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_ta = 0; m_tflag = 0;
  endtask

  task automatic model_check();
    logic [N-1:0]    e_grant, e_hold, e_rv, e_rdy;
    logic [N*64-1:0] e_rdata;
    logic [26:0]     e_addr;
    logic [4:0]      e_strb;
    logic [63:0]     e_wdata;
    logic [7:0]      e_mask;
    logic            e_to;
    e_grant = '0; e_rv = '0; e_rdy = '0; e_rdata = '0;
    e_addr = '0; e_strb = '0; e_wdata = '0; e_mask = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_addr  = cl_addr[m_owner*27 +: 27];
      e_strb  = {cl_write[m_owner], cl_read[m_owner], cl_push[m_owner],
                 cl_pull[m_owner], cl_done[m_owner]};
      e_wdata = cl_wdata[m_owner*64 +: 64];
      e_mask  = cl_mask[m_owner*8 +: 8];
      e_rdata[m_owner*64 +: 64] = ddr_rdata;
      e_rv[m_owner]  = ddr_rvalid;
      e_rdy[m_owner] = ddr_ready;
    end
    e_hold = ~e_grant;
    e_to   = m_tflag || (m_owner >= 0 && m_cnt + 1 >= TO);
    chk("grant", grant, e_grant);
    chk("hold", hold, e_hold);
    chk("ddr_address", ddr_addr, e_addr);
    chk("ddr_strobes", {ddr_write, ddr_read, ddr_push, ddr_pull, ddr_done}, e_strb);
    chk("ddr_write_data", ddr_wdata, e_wdata);
    chk("ddr_write_mask", ddr_mask, e_mask);
    chk("cl_read_data", cl_rdata, e_rdata);
    chk("cl_read_valid", cl_rvalid, e_rv);
    chk("cl_ready", cl_ready, e_rdy);
    chk("timeout", timeout, e_to);
  endtask

  task automatic model_update();
    if (m_owner >= 0) begin
      if (m_cnt < TO) m_cnt++;
      if (m_cnt >= TO) m_tflag = 1;
      if (rel[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_ta    = 1;
      end
    end else if (m_ta) begin
      m_ta = 0;
    end else if (ddr_ready && req != '0) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (req[p]) begin
          m_owner = p;
          m_cnt   = 0;
          break;
        end
      end
    end
  endtask

  // Called at posedge+1; applies inputs for one cycle, checks at negedge, advances model at posedge.
  task automatic step(input logic [N-1:0] rq, input logic [N-1:0] rl, input logic rdy);
    req = rq; rel = rl; ddr_ready = rdy;
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; rel = '0; ddr_ready = 1'b1;
    cl_write = '0; cl_read = '0; cl_push = '0; cl_pull = '0; cl_done = '0;
    cl_addr = {27'h0000200, 27'h0000100};
    cl_wdata = '0; cl_mask = '0; ddr_rdata = '0; ddr_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    model_check();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    //        req    rel    rdy   grant  hold   ready  addr
    tbl[0]  = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b11, 2'b00, 27'h0};
    tbl[1]  = '{2'b01, 2'b00, 1'b1, 2'b00, 2'b11, 2'b00, 27'h0};
    tbl[2]  = '{2'b01, 2'b00, 1'b1, 2'b01, 2'b10, 2'b01, 27'h0000100};
    tbl[3]  = '{2'b01, 2'b01, 1'b1, 2'b01, 2'b10, 2'b01, 27'h0000100};
    tbl[4]  = '{2'b11, 2'b00, 1'b1, 2'b00, 2'b11, 2'b00, 27'h0};
    tbl[5]  = '{2'b11, 2'b00, 1'b1, 2'b00, 2'b11, 2'b00, 27'h0};
    tbl[6]  = '{2'b11, 2'b01, 1'b1, 2'b10, 2'b01, 2'b10, 27'h0000200};
    tbl[7]  = '{2'b11, 2'b10, 1'b1, 2'b10, 2'b01, 2'b10, 27'h0000200};
    tbl[8]  = '{2'b11, 2'b00, 1'b1, 2'b00, 2'b11, 2'b00, 27'h0};
    tbl[9]  = '{2'b11, 2'b00, 1'b1, 2'b00, 2'b11, 2'b00, 27'h0};
    tbl[10] = '{2'b11, 2'b01, 1'b0, 2'b01, 2'b10, 2'b00, 27'h0000100};
    tbl[11] = '{2'b11, 2'b00, 1'b1, 2'b00, 2'b11, 2'b00, 27'h0};
    tbl[12] = '{2'b11, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 27'h0};
    tbl[13] = '{2'b11, 2'b00, 1'b1, 2'b00, 2'b11, 2'b00, 27'h0};
    tbl[14] = '{2'b00, 2'b00, 1'b1, 2'b10, 2'b01, 2'b10, 27'h0000200};
    tbl[15] = '{2'b00, 2'b10, 1'b1, 2'b10, 2'b01, 2'b10, 27'h0000200};
    tbl[16] = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b11, 2'b00, 27'h0};
    tbl[17] = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b11, 2'b00, 27'h0};

    do_reset();

    for (int i = 0; i < 18; i++) begin
      req = tbl[i].req; rel = tbl[i].rel; ddr_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d grant", i), grant, tbl[i].grant);
      chk($sformatf("tbl%0d hold", i), hold, tbl[i].hold);
      chk($sformatf("tbl%0d cl_ready", i), cl_ready, tbl[i].ready);
      chk($sformatf("tbl%0d ddr_address", i), ddr_addr, tbl[i].addr);
      model_check();
      @(posedge clk);
      model_update();
      #1;
    end

    // Continuous requests, 4-cycle transactions: grants alternate, gap cycle carries no write.
    cl_write = '1;
    for (int t = 0; t < 4; t++) begin
      logic [N-1:0] exp_g;
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      step(2'b11, 2'b00, 1'b1);
      chk($sformatf("rotation%0d grant", t), grant, exp_g);
      for (int c = 0; c < 4; c++) step(2'b11, (c == 3) ? exp_g : 2'b00, 1'b1);
      chk($sformatf("rotation%0d turnaround write", t), ddr_write, 1'b0);
      chk($sformatf("rotation%0d turnaround grant", t), grant, 2'b00);
      step(2'b11, 2'b00, 1'b1);
    end
    cl_write = '0;

    // Read return steered to owner 0 only; non-owner release is ignored.
    step(2'b01, 2'b00, 1'b1);
    ddr_rvalid = 1'b1;
    ddr_rdata  = {32'hDEADBEEF, 32'h12345678};
    #1;
    chk("read owner data", cl_rdata[63:0], {32'hDEADBEEF, 32'h12345678});
    chk("read owner valid", cl_rvalid[0], 1'b1);
    chk("read other valid", cl_rvalid[1], 1'b0);
    chk("read other data", cl_rdata[127:64], 64'h0);
    step(2'b01, 2'b10, 1'b1);
    chk("foreign release grant", grant, 2'b01);
    step(2'b01, 2'b00, 1'b1);
    chk("foreign release grant2", grant, 2'b01);
    step(2'b01, 2'b01, 1'b1);
    chk("own release grant", grant, 2'b00);
    ddr_rvalid = 1'b0;
    step(2'b00, 2'b00, 1'b1);
    step(2'b00, 2'b00, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] rl;
      cl_addr    = 54'({$urandom, $urandom});
      cl_wdata   = {$urandom, $urandom, $urandom, $urandom};
      cl_mask    = 16'($urandom);
      cl_write   = 2'($urandom); cl_read = 2'($urandom); cl_push = 2'($urandom);
      cl_pull    = 2'($urandom); cl_done = 2'($urandom);
      ddr_rdata  = {$urandom, $urandom};
      ddr_rvalid = 1'($urandom);
      rl = '0;
      if (m_owner >= 0 && $urandom_range(0, 3) == 0) rl[m_owner] = 1'b1;
      if ($urandom_range(0, 7) == 0) rl[$urandom_range(0, N-1)] = 1'b1;
      step(2'($urandom), rl, ($urandom_range(0, 4) != 0));
    end

    // Timeout: owner never releases; flag on the 16th owned cycle, sticky until reset.
    do_reset();
    step(2'b01, 2'b00, 1'b1);
    chk("timeout cycle1", timeout, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      step(2'b01, 2'b00, 1'b1);
      chk($sformatf("timeout cycle%0d", k + 1), timeout, (k + 1 >= TO) ? 1'b1 : 1'b0);
    end
    step(2'b01, 2'b00, 1'b1);
    step(2'b01, 2'b01, 1'b1);
    step(2'b00, 2'b00, 1'b1);
    step(2'b00, 2'b00, 1'b1);
    chk("timeout sticky after release", timeout, 1'b1);
    do_reset();
    chk("timeout cleared by reset", timeout, 1'b0);

    // Asynchronous reset in the middle of an owned push.
    step(2'b10, 2'b00, 1'b1);
    cl_push = 2'b10;
    #2;
    chk("push before reset", ddr_push, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async reset push", ddr_push, 1'b0);
    chk("async reset hold", hold, 2'b11);
    chk("async reset grant", grant, 2'b00);
    model_reset();
    cl_push = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2'b11, 2'b00, 1'b1);
    chk("grant after reset", grant, 2'b01);
    step(2'b11, 2'b01, 1'b1);
    step(2'b00, 2'b00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Shares the single DDR user port (command, data push/pull, read return, status) between NUM_PORTS cache-to-DDR bridge clients, e.g. port 0 instruction cache and port 1 data cache.
- Drives each client's hold input and grants one owner at a time, round-robin.
- Ownership lasts for a whole transaction, from grant to the client's release pulse.
- Multiplexes owner signals to the DDR controller and steers read return data to the owner only.

Parameters:
- NUM_PORTS, 2, number of client bridges (2..4).
- TIMEOUT_CYCLES, 1024, owner cycles before the sticky timeout flag is raised; 0 disables the check.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; one clock, asynchronous, active-low.
- req_i  in  NUM_PORTS  client n has a transaction ready (level).
- release_i  in  NUM_PORTS  one-cycle pulse from the owner marking its last DDR beat.
- hold_o  out  NUM_PORTS  stall to client n; 0 only for the current owner.
- grant_o  out  NUM_PORTS  one-hot owner vector; all zero when idle.
- cl_address_i  in  NUM_PORTS x 27  client addresses.
- cl_write_i, cl_read_i, cl_push_i, cl_pull_i, cl_done_i  in  NUM_PORTS each  client command/data strobes.
- cl_write_data_i  in  NUM_PORTS x 64  client write data.
- cl_write_mask_i  in  NUM_PORTS x 8  client byte masks.
- cl_read_data_o  out  NUM_PORTS x 2x32  read data to each client.
- cl_read_valid_o  out  NUM_PORTS  read valid to each client.
- cl_ready_o  out  NUM_PORTS  DDR ready to each client.
- ddr_address_o  out  27  muxed address to the DDR controller.
- ddr_write_o, ddr_read_o, ddr_push_o, ddr_pull_o, ddr_done_o  out  1 each  muxed strobes.
- ddr_write_data_o  out  64  muxed write data.
- ddr_write_mask_o  out  8  muxed byte mask.
- ddr_read_data_i  in  2x32  read data from the DDR controller.
- ddr_read_valid_i  in  1  read valid from the DDR controller.
- ddr_ready_i  in  1  DDR controller ready.
- timeout_o  out  1  sticky timeout flag.

Behaviour:
- Reset values: state IDLE, hold_o all ones, grant_o 0, round-robin pointer 0, timeout counter 0, timeout_o 0. All ddr_* outputs are 0 because there is no owner.
- FSM states IDLE, OWNED, TURNAROUND.
- IDLE:
  - If ddr_ready_i and any req_i bit is set, pick the first requester at or after the pointer, cyclically.
  - Register grant_o as that one-hot and go to OWNED. The owner's hold_o drops the cycle after the decision (1-cycle grant latency).
  - With no request or !ddr_ready_i, stay in IDLE.
- OWNED:
  - ddr_* outputs = owner's cl_* inputs, combinationally. Non-owner strobes are ignored.
  - cl_ready_o[owner] = ddr_ready_i; cl_ready_o of all others = 0.
  - The read path is a pure mux: cl_read_valid_o[owner] = ddr_read_valid_i and cl_read_data_o[owner] = ddr_read_data_i. Non-owners see valid 0 and data 0.
  - release_i[owner] in the same cycle: that cycle's strobes still pass through. Next state TURNAROUND; pointer <= owner+1 modulo NUM_PORTS; grant_o cleared; all hold_o set.
  - release_i from a non-owner is ignored.
  - Owner dropping req_i without a release does not end ownership; only release ends it.
- TURNAROUND:
  - One mandatory idle cycle with all ddr_* = 0, then IDLE.
  - Guarantees no back-to-back strobes from different clients.
- Fairness: with all ports requesting continuously, grants rotate 0,1,...,NUM_PORTS-1. Worst-case wait = (NUM_PORTS-1) transactions + (NUM_PORTS-1)x2 arbitration cycles.
- Timeout:
  - Counter clears on entry to OWNED and increments every OWNED cycle, saturating.
  - When it reaches TIMEOUT_CYCLES, timeout_o is set and held until reset.
  - No forced release: recovery is left to software/reset.
- Simultaneous events: a req_i arriving in the same cycle the owner releases is arbitrated in the IDLE after TURNAROUND, using the updated pointer.
- Mid-operation reset: asynchronous return to reset values. Ownership is lost and outputs go to 0 immediately.

Decomposition:
- Shared package entry: arbiter state enum (IDLE/OWNED/TURNAROUND).
- Shared package entry: typedef for the client command bundle (address, write, read, push, pull, done, data, mask).
- Sub-module round_robin_picker: combinational first-set search from the pointer, returning a one-hot vector and a found flag. It is reusable for the later peripheral arbiters.

Test Plan:
- Reset release, req_i=2'b01, ddr_ready_i=1 -> grant_o=2'b01 one cycle later; hold_o=2'b10; owner address 0x0000100 appears on ddr_address_o.
- req_i=2'b11 held continuously with a 4-cycle transaction per client -> grants alternate 01,10,01,10 with one TURNAROUND cycle between, and ddr_write_o is never asserted in TURNAROUND.
- Client 0 owns; ddr_read_valid_i=1 with data {0xDEADBEEF,0x12345678} -> cl_read_data_o[0] carries it; cl_read_valid_o[1]=0 and cl_read_data_o[1]=0.
- release_i[1] pulsed while client 0 owns -> no state change; client 0 keeps grant until release_i[0].
- TIMEOUT_CYCLES=16, owner never releases -> timeout_o=1 on the 16th OWNED cycle; it stays 1 after a later release and clears only on rst_n_i low.
- rst_n_i asserted mid-OWNED with push active -> ddr_push_o=0 and hold_o all ones without waiting for a clock edge; the next grant after reset goes to port 0.
